// File: rtl/msrv32_store_unit.sv
// Store unit for the MSRV32 core: converts an execute-stage store into a
// single AHB-style write (address phase then data phase), with byte-lane
// steering, misalignment rejection, bus-error reporting and a wait timeout.
module msrv32_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic        store_req_in,
    input  logic [1:0]  load_size_in,
    input  logic [31:0] iadder_in,
    input  logic [31:0] rs2_in,
    input  logic        ahb_ready_in,
    input  logic        ahb_resp_in,
    output logic [31:0] ms_riscv32_mp_dmaddr_out,
    output logic [31:0] ms_riscv32_mp_dmdata_out,
    output logic [3:0]  ms_riscv32_mp_dmwr_mask_out,
    output logic        ms_riscv32_mp_dmwr_req_out,
    output logic [1:0]  ahb_htrans_out,
    output logic        store_busy_out,
    output logic        store_done_out,
    output logic        store_err_out,
    output logic        misaligned_out
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        DATA = 2'b10
    } state_t;

    localparam logic [1:0] HTRANS_IDLE    = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ  = 2'b10;
    localparam logic [7:0] TIMEOUT_LIMIT  = 8'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  mask_q, mask_d;
    logic [1:0]  htrans_q, htrans_d;
    logic        wr_req_q, wr_req_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        misaligned_q, misaligned_d;

    logic        req_misaligned;
    logic [31:0] lane_data;
    logic [3:0]  lane_mask;
    logic [7:0]  wait_inc;
    logic        wait_expired;

    // Decode the incoming request: alignment check plus lane-replicated data and strobes.
    always_comb begin
        req_misaligned = 1'b0;
        lane_data      = rs2_in;
        lane_mask      = 4'b1111;
        unique case (load_size_in)
            2'b00: begin
                lane_data = {4{rs2_in[7:0]}};
                lane_mask = 4'b0001 << iadder_in[1:0];
            end
            2'b01: begin
                req_misaligned = iadder_in[0];
                lane_data      = {2{rs2_in[15:0]}};
                lane_mask      = iadder_in[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                req_misaligned = |iadder_in[1:0];
            end
        endcase
    end

    assign wait_inc     = wait_cnt_q + 8'd1;
    assign wait_expired = (wait_inc == TIMEOUT_LIMIT);

    // Next-state, capture and pulse logic; bus outputs are derived from the next state so they leave a flop.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned and infers a latch.
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        addr_d       = addr_q;
        data_d       = data_q;
        mask_d       = mask_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        misaligned_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (store_req_in) begin
                    if (req_misaligned) begin
                        misaligned_d = 1'b1;
                    end else begin
                        state_d    = ADDR;
                        wait_cnt_d = 8'd0;
                        addr_d     = {iadder_in[31:2], 2'b00};
                        data_d     = lane_data;
                        mask_d     = lane_mask;
                    end
                end
            end
            ADDR: begin
                if (ahb_ready_in) begin
                    state_d    = DATA;
                    wait_cnt_d = 8'd0;
                end else if (wait_expired) begin
                    state_d    = IDLE;
                    wait_cnt_d = 8'd0;
                    err_d      = 1'b1;
                end else begin
                    wait_cnt_d = wait_inc;
                end
            end
            DATA: begin
                if (ahb_ready_in) begin
                    state_d    = IDLE;
                    wait_cnt_d = 8'd0;
                    err_d      = ahb_resp_in;
                    done_d     = ~ahb_resp_in;
                end else if (wait_expired) begin
                    state_d    = IDLE;
                    wait_cnt_d = 8'd0;
                    err_d      = 1'b1;
                end else begin
                    wait_cnt_d = wait_inc;
                end
            end
            default: begin
                state_d    = IDLE;
                wait_cnt_d = 8'd0;
            end
        endcase

        htrans_d = (state_d == ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
        wr_req_d = (state_d == ADDR);
        busy_d   = (state_d != IDLE);
    end

    // State and output registers; reset clears everything without waiting for a clock.
    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state_q      <= IDLE;
            wait_cnt_q   <= 8'd0;
            addr_q       <= 32'd0;
            data_q       <= 32'd0;
            mask_q       <= 4'd0;
            htrans_q     <= HTRANS_IDLE;
            wr_req_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            mask_q       <= mask_d;
            htrans_q     <= htrans_d;
            wr_req_q     <= wr_req_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign ms_riscv32_mp_dmaddr_out    = addr_q;
    assign ms_riscv32_mp_dmdata_out    = data_q;
    assign ms_riscv32_mp_dmwr_mask_out = mask_q;
    assign ms_riscv32_mp_dmwr_req_out  = wr_req_q;
    assign ahb_htrans_out              = htrans_q;
    assign store_busy_out              = busy_q;
    assign store_done_out              = done_q;
    assign store_err_out               = err_q;
    assign misaligned_out              = misaligned_q;

endmodule

// File: tb/tb_msrv32_store_unit.sv
// Directed bench for msrv32_store_unit: each task drives one scenario and
// compares outputs against hand-computed values one cycle at a time.
module tb_msrv32_store_unit;

    logic        clk;
    logic        rst;
    logic        store_req;
    logic [1:0]  size;
    logic [31:0] iadder;
    logic [31:0] rs2;
    logic        ready;
    logic        resp;
    logic [31:0] dmaddr;
    logic [31:0] dmdata;
    logic [3:0]  mask;
    logic        wr_req;
    logic [1:0]  htrans;
    logic        busy;
    logic        done;
    logic        err;
    logic        mis;

    // {wr_req, htrans, busy, done, err, misaligned}
    logic [6:0]  ctl;

    localparam logic [6:0] C_IDLE = 7'b0_00_0_000;
    localparam logic [6:0] C_ADDR = 7'b1_10_1_000;
    localparam logic [6:0] C_DATA = 7'b0_00_1_000;
    localparam logic [6:0] C_DONE = 7'b0_00_0_100;
    localparam logic [6:0] C_ERR  = 7'b0_00_0_010;
    localparam logic [6:0] C_MIS  = 7'b0_00_0_001;

    int vectors;
    int miscompares;

    assign ctl = {wr_req, htrans, busy, done, err, mis};

    msrv32_store_unit #(.TIMEOUT_CYCLES(16)) dut (
        .ms_riscv32_mp_clk_in        (clk),
        .ms_riscv32_mp_rst_in        (rst),
        .store_req_in                (store_req),
        .load_size_in                (size),
        .iadder_in                   (iadder),
        .rs2_in                      (rs2),
        .ahb_ready_in                (ready),
        .ahb_resp_in                 (resp),
        .ms_riscv32_mp_dmaddr_out    (dmaddr),
        .ms_riscv32_mp_dmdata_out    (dmdata),
        .ms_riscv32_mp_dmwr_mask_out (mask),
        .ms_riscv32_mp_dmwr_req_out  (wr_req),
        .ahb_htrans_out              (htrans),
        .store_busy_out              (busy),
        .store_done_out              (done),
        .store_err_out               (err),
        .misaligned_out              (mis)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp_ctl(input string name, input logic [6:0] exp);
        vectors++;
        if (ctl !== exp) begin
            miscompares++;
            $display("FAIL %s: ctl got %b expected %b at %0t", name, ctl, exp, $time);
        end
    endtask

    task automatic cmp32(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; store_req = 1'b0; size = 2'b00; iadder = '0; rs2 = '0;
        ready = 1'b1; resp = 1'b0;
        #1 rst = 1'b1;
        #1;
        cmp_ctl("reset_ctl", C_IDLE);
        cmp32("reset_addr", dmaddr, 32'h0);
        cmp32("reset_data", dmdata, 32'h0);
        cmp32("reset_mask", {28'h0, mask}, 32'h0);
        tick();
        tick();
        @(negedge clk);
        rst = 1'b0;
        tick();
        cmp_ctl("reset_idle_after_release", C_IDLE);
    endtask

    task automatic test_sb();
        store_req = 1'b1; size = 2'b00; iadder = 32'h0000_1003; rs2 = 32'h0000_00A5;
        ready = 1'b1; resp = 1'b0;
        tick();
        store_req = 1'b0;
        cmp_ctl("sb_addr_phase", C_ADDR);
        cmp32("sb_addr", dmaddr, 32'h0000_1000);
        cmp32("sb_mask", {28'h0, mask}, 32'h8);
        tick();
        cmp_ctl("sb_data_phase", C_DATA);
        cmp32("sb_data", dmdata, 32'hA5A5_A5A5);
        tick();
        cmp_ctl("sb_done_n3", C_DONE);
        tick();
        cmp_ctl("sb_idle_after", C_IDLE);
    endtask

    task automatic test_sh_wait();
        store_req = 1'b1; size = 2'b01; iadder = 32'h0000_2002; rs2 = 32'h1234_BEEF;
        ready = 1'b1; resp = 1'b0;
        tick();
        store_req = 1'b0;
        iadder = 32'h0000_0000; rs2 = 32'h0000_0000; size = 2'b10;
        cmp_ctl("sh_addr_phase", C_ADDR);
        cmp32("sh_addr", dmaddr, 32'h0000_2000);
        cmp32("sh_mask", {28'h0, mask}, 32'hC);
        tick();
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cmp_ctl("sh_data_wait", C_DATA);
            cmp32("sh_data_wait", dmdata, 32'hBEEF_BEEF);
            tick();
        end
        ready = 1'b1;
        cmp_ctl("sh_data_last", C_DATA);
        cmp32("sh_data_last", dmdata, 32'hBEEF_BEEF);
        tick();
        cmp_ctl("sh_done_n6", C_DONE);
        tick();
        cmp_ctl("sh_idle_after", C_IDLE);
    endtask

    task automatic test_misaligned();
        store_req = 1'b1; size = 2'b10; iadder = 32'h0000_3002; rs2 = 32'h1111_2222;
        ready = 1'b1; resp = 1'b0;
        tick();
        store_req = 1'b0;
        cmp_ctl("sw_misaligned_pulse", C_MIS);
        tick();
        cmp_ctl("sw_misaligned_end", C_IDLE);
        store_req = 1'b1; size = 2'b01; iadder = 32'h0000_3001;
        tick();
        store_req = 1'b0;
        cmp_ctl("sh_misaligned_pulse", C_MIS);
        tick();
        cmp_ctl("sh_misaligned_end", C_IDLE);
    endtask

    task automatic test_bus_error();
        store_req = 1'b1; size = 2'b10; iadder = 32'h0000_4000; rs2 = 32'hDEAD_BEEF;
        ready = 1'b1; resp = 1'b0;
        tick();
        store_req = 1'b0;
        cmp_ctl("err_addr_phase", C_ADDR);
        cmp32("err_mask", {28'h0, mask}, 32'hF);
        tick();
        resp = 1'b1;
        cmp_ctl("err_data_phase", C_DATA);
        cmp32("err_data", dmdata, 32'hDEAD_BEEF);
        tick();
        resp = 1'b0;
        cmp_ctl("err_pulse", C_ERR);
        tick();
        cmp_ctl("err_idle_after", C_IDLE);
    endtask

    task automatic test_timeout();
        store_req = 1'b1; size = 2'b10; iadder = 32'h0000_5000; rs2 = 32'h0BAD_F00D;
        ready = 1'b1; resp = 1'b0;
        tick();
        store_req = 1'b0;
        ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cmp_ctl("timeout_addr_held", C_ADDR);
            tick();
        end
        cmp_ctl("timeout_err_pulse", C_ERR);
        ready = 1'b1;
        tick();
        cmp_ctl("timeout_idle_after", C_IDLE);
    endtask

    task automatic test_back_to_back();
        store_req = 1'b1; size = 2'b10; iadder = 32'h0000_7000; rs2 = 32'h1122_3344;
        ready = 1'b1; resp = 1'b0;
        tick();
        size = 2'b01; iadder = 32'h0000_7002; rs2 = 32'hCAFE_F00D;
        cmp_ctl("b2b_first_addr", C_ADDR);
        cmp32("b2b_first_addr", dmaddr, 32'h0000_7000);
        cmp32("b2b_first_mask", {28'h0, mask}, 32'hF);
        tick();
        cmp_ctl("b2b_first_data", C_DATA);
        cmp32("b2b_first_data", dmdata, 32'h1122_3344);
        tick();
        cmp_ctl("b2b_first_done", C_DONE);
        tick();
        store_req = 1'b0;
        cmp_ctl("b2b_second_addr", C_ADDR);
        cmp32("b2b_second_mask", {28'h0, mask}, 32'hC);
        cmp32("b2b_second_data", dmdata, 32'hF00D_F00D);
        tick();
        cmp_ctl("b2b_second_data", C_DATA);
        tick();
        cmp_ctl("b2b_second_done", C_DONE);
        tick();
        cmp_ctl("b2b_idle_after", C_IDLE);
    endtask

    task automatic test_reset_mid();
        store_req = 1'b1; size = 2'b10; iadder = 32'h0000_8000; rs2 = 32'h5555_AAAA;
        ready = 1'b1; resp = 1'b0;
        tick();
        store_req = 1'b0;
        tick();
        ready = 1'b0;
        cmp_ctl("rstmid_data_phase", C_DATA);
        tick();
        #2 rst = 1'b1;
        #1;
        cmp_ctl("rstmid_async_ctl", C_IDLE);
        cmp32("rstmid_async_addr", dmaddr, 32'h0);
        cmp32("rstmid_async_data", dmdata, 32'h0);
        tick();
        ready = 1'b1;
        store_req = 1'b1; size = 2'b00; iadder = 32'h0000_6001; rs2 = 32'h0000_005A;
        @(negedge clk);
        rst = 1'b0;
        tick();
        store_req = 1'b0;
        cmp_ctl("rstmid_new_sb_addr", C_ADDR);
        cmp32("rstmid_new_sb_addr", dmaddr, 32'h0000_6000);
        cmp32("rstmid_new_sb_mask", {28'h0, mask}, 32'h2);
        tick();
        cmp_ctl("rstmid_new_sb_data", C_DATA);
        cmp32("rstmid_new_sb_data", dmdata, 32'h5A5A_5A5A);
        tick();
        cmp_ctl("rstmid_new_sb_done", C_DONE);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_sb();
        test_sh_wait();
        test_misaligned();
        test_bus_error();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/msrv32_store_unit.md
MSRV32_STORE_UNIT -- requirements
Module: msrv32_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: maximum consecutive ready-low cycles in one transfer before abort (legal range 2..255).
REQ-002 ms_riscv32_mp_clk_in  input  1  single clock; all state changes on its rising edge.
REQ-003 ms_riscv32_mp_rst_in  input  1  reset, asynchronous, active-high.
REQ-004 store_req_in  input  1  store request from execute stage; sampled only in IDLE.
REQ-005 load_size_in  input  2  00 byte, 01 half, 10/11 word.
REQ-006 iadder_in  input  32  effective byte address.
REQ-007 rs2_in  input  32  store data, right-justified.
REQ-008 ahb_ready_in  input  1  bus ready (HREADY); 1 completes the current phase.
REQ-009 ahb_resp_in  input  1  bus response, 0 OKAY, 1 ERROR; valid when ahb_ready_in=1.
REQ-010 ms_riscv32_mp_dmaddr_out  output  32  word-aligned address {iadder[31:2],2'b00}.
REQ-011 ms_riscv32_mp_dmdata_out  output  32  lane-replicated write data.
REQ-012 ms_riscv32_mp_dmwr_mask_out  output  4  byte-lane write strobes.
REQ-013 ms_riscv32_mp_dmwr_req_out  output  1  write request, high in address phase.
REQ-014 ahb_htrans_out  output  2  10 NONSEQ in address phase, else 00 IDLE.
REQ-015 store_busy_out  output  1  pipeline stall, high whenever state is not IDLE.
REQ-016 store_done_out  output  1  one-cycle pulse, OKAY completion.
REQ-017 store_err_out  output  1  one-cycle pulse, bus ERROR or timeout.
REQ-018 misaligned_out  output  1  one-cycle pulse, misaligned request rejected.

Function
REQ-019 States IDLE, ADDR, DATA; all outputs registered.
REQ-020 Misaligned: half with iadder[0]=1, or word with iadder[1:0]!=00.
REQ-021 IDLE with store_req_in=1 and not misaligned: capture address/data/mask, next state ADDR.
REQ-022 IDLE with store_req_in=1 and misaligned: misaligned_out=1 next cycle, remain IDLE, no bus activity.
REQ-023 Data: byte -> {4{rs2[7:0]}}; half -> {2{rs2[15:0]}}; word -> rs2.
REQ-024 Mask: byte -> 4'b0001 << iadder[1:0]; half -> 0011 (iadder[1]=0) or 1100 (iadder[1]=1); word -> 1111.
REQ-025 ADDR: htrans=10, dmwr_req=1, address and mask valid; ahb_ready_in=1 moves to DATA, else ADDR held with outputs stable.
REQ-026 DATA: htrans=00, dmwr_req=0, dmdata valid and stable; ahb_ready_in=1 moves to IDLE.
REQ-027 DATA exit with ahb_resp_in=0: store_done_out=1 for the following cycle; with ahb_resp_in=1: store_err_out=1 instead.
REQ-028 Wait counter: cleared on each state entry, increments each ready-low cycle in ADDR or DATA.
REQ-029 Counter reaching TIMEOUT_CYCLES: abort to IDLE, store_err_out=1 next cycle, htrans/dmwr_req deasserted.
REQ-030 Best-case latency: request accepted at cycle N; ADDR at N+1; DATA at N+2; done pulse and IDLE at N+3.
REQ-031 store_req_in ignored outside IDLE; next request accepted no earlier than the cycle store_done_out/store_err_out is high.
REQ-032 done, err, and misaligned pulses mutually exclusive, each exactly one cycle.
REQ-033 Captured address/data/mask unaffected by input changes after acceptance.

Reset
REQ-034 Reset asserted: immediately (without clock) state IDLE, counter 0, all outputs 0.
REQ-035 Reset mid-transfer: abandon transfer, no done/err pulse at or after deassertion.
REQ-036 First request accepted on first rising edge after reset deassertion.

Verification
REQ-037 SB, iadder=0x1003, rs2=0x000000A5, ready=1 -> ADDR: dmaddr 0x1000, mask 1000, htrans 10; DATA: dmdata 0xA5A5A5A5; done pulse at N+3.
REQ-038 SH, iadder=0x2002, rs2=0x1234BEEF, ready low 3 DATA cycles -> mask 1100, dmdata 0xBEEFBEEF held 4 cycles; done at N+6.
REQ-039 SW, iadder=0x3002 -> misaligned_out pulse next cycle, dmwr_req/htrans stay 0, busy stays 0.
REQ-040 SW, iadder=0x4000, ready=1 with resp=1 in DATA -> store_err_out pulse, no done, IDLE.
REQ-041 SW, ready held low in ADDR, TIMEOUT_CYCLES=16 -> abort after 16 wait cycles, err pulse, htrans 00.
REQ-042 Reset asserted in DATA mid-wait -> outputs 0 without clock edge; no pulse after release; new SB accepted next edge.
